// File: rtl/parking_occupancy_ctrl.sv
// Car park occupancy tracker that drives an external 4-bit adder/subtractor and the entry/exit gates.
// Define PARK_DEBOUNCE_EN to build per-sensor debounce filters after the synchronizers.
module parking_occupancy_ctrl #(
  parameter int CAPACITY        = 15,
  parameter int GATE_CYCLES     = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_sensor,
  input  logic       exit_sensor,
  output logic       add_sub_s,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  input  logic [4:0] add_sum,
  output logic [3:0] count,
  output logic       full,
  output logic       empty,
  output logic       gate_in_open,
  output logic       gate_out_open,
  output logic       reject,
  output logic       missed
);

  localparam logic [3:0]    CAP       = 4'(CAPACITY);
  localparam int            GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_COMMIT, ST_GATE} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_NET, OP_REJ} op_t;

  logic [1:0]    r_entrySync;
  logic [1:0]    r_exitSync;
  logic [1:0]    w_level;
  logic [1:0]    w_clean;
  logic [1:0]    r_prevClean;
  logic [1:0]    w_edge;
  logic          r_pendIn;
  logic          r_pendOut;
  logic          w_take;
  state_t        r_state;
  state_t        w_nextState;
  op_t           r_op;
  op_t           w_decOp;
  logic [3:0]    r_count;
  logic [3:0]    r_sumLatched;
  logic [GW-1:0] r_gateCnt;

  // Out-of-range configurations leave this marker block in the elaborated hierarchy.
  if (CAPACITY < 1 || CAPACITY > 15 || GATE_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_invalidParams
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_entrySync <= '0;
      r_exitSync  <= '0;
    end else begin
      r_entrySync <= {r_entrySync[0], entry_sensor};
      r_exitSync  <= {r_exitSync[0], exit_sensor};
    end
  end

  // Bit 0 carries the entry direction, bit 1 the exit direction.
  assign w_level = {r_exitSync[1], r_entrySync[1]};

`ifdef PARK_DEBOUNCE_EN
  localparam int             DBW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]     r_stable;
  logic [DBW-1:0] r_dbCnt [2];

  // A new level is accepted only after it has differed from the stable level for DEBOUNCE_CYCLES clocks in a row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stable   <= '0;
      r_dbCnt[0] <= '0;
      r_dbCnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_level[i] == r_stable[i]) begin
          r_dbCnt[i] <= '0;
        end else if (r_dbCnt[i] == DB_LAST) begin
          r_stable[i] <= w_level[i];
          r_dbCnt[i]  <= '0;
        end else begin
          r_dbCnt[i] <= r_dbCnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_clean = r_stable;
`else
  assign w_clean = w_level;
`endif

  assign w_edge = w_clean & ~r_prevClean;
  assign missed = (w_edge[0] & r_pendIn) | (w_edge[1] & r_pendOut);
  assign w_take = (r_state == ST_IDLE) && (r_pendIn || r_pendOut);

  assign count = r_count;
  assign add_a = r_count;
  assign full  = (r_count == CAP);
  assign empty = (r_count == 4'd0);

  // Simultaneous requests cancel out, even at the capacity limits.
  always_comb begin
    w_decOp = OP_NET;
    if (r_pendIn && !r_pendOut) begin
      w_decOp = full ? OP_REJ : OP_ADD;
    end else if (r_pendOut && !r_pendIn) begin
      w_decOp = empty ? OP_REJ : OP_SUB;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    add_sub_s     = 1'b0;
    add_b         = 4'd0;
    reject        = 1'b0;
    gate_in_open  = 1'b0;
    gate_out_open = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_pendIn || r_pendOut) begin
          w_nextState = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_nextState = ST_COMMIT;
        add_sub_s   = (r_op == OP_SUB);
        add_b       = (r_op == OP_ADD || r_op == OP_SUB) ? 4'd1 : 4'd0;
        reject      = (r_op == OP_REJ);
      end
      ST_COMMIT: begin
        w_nextState = (r_op == OP_REJ) ? ST_IDLE : ST_GATE;
      end
      ST_GATE: begin
        gate_in_open  = (r_op == OP_ADD || r_op == OP_NET);
        gate_out_open = (r_op == OP_SUB || r_op == OP_NET);
        if (r_gateCnt == GATE_LAST) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // The adder result is captured while B is applied in ISSUE and written to the count in COMMIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prevClean  <= '0;
      r_pendIn     <= 1'b0;
      r_pendOut    <= 1'b0;
      r_op         <= OP_ADD;
      r_count      <= 4'd0;
      r_sumLatched <= 4'd0;
      r_gateCnt    <= '0;
    end else begin
      r_prevClean <= w_clean;
      r_pendIn    <= (r_pendIn & ~w_take) | (w_edge[0] & ~r_pendIn);
      r_pendOut   <= (r_pendOut & ~w_take) | (w_edge[1] & ~r_pendOut);
      if (w_take) begin
        r_op <= w_decOp;
      end
      if (r_state == ST_ISSUE) begin
        r_sumLatched <= add_sum[3:0];
      end
      if (r_state == ST_COMMIT) begin
        r_count <= r_sumLatched;
      end
      if (r_state == ST_GATE) begin
        r_gateCnt <= r_gateCnt + 1'b1;
      end else begin
        r_gateCnt <= '0;
      end
    end
  end

  assert property (@(posedge clk) disable iff (reset)
    (r_state == ST_ISSUE && r_op == OP_SUB) |-> add_sum[4]);
  assert property (@(posedge clk) disable iff (reset)
    (r_state == ST_ISSUE && r_op == OP_ADD) |-> !add_sum[4]);

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Scoreboard bench for parking_occupancy_ctrl: an occupancy model predicts each service event,
// and a monitor compares every reject pulse and gate opening against the predicted event.
module tb_parking_occupancy_ctrl;

   localparam int CAP  = 15;
   localparam int GATE = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       entry_sensor = 1'b0;
   logic       exit_sensor = 1'b0;
   logic       add_sub_s;
   logic [3:0] add_a;
   logic [3:0] add_b;
   logic [4:0] add_sum;
   logic [3:0] count;
   logic       full;
   logic       empty;
   logic       gate_in_open;
   logic       gate_out_open;
   logic       reject;
   logic       missed;

   typedef enum int {K_ADD, K_SUB, K_NET, K_REJ} kind_t;
   typedef struct {
      kind_t kind;
      int    cnt;
   } exp_t;

   exp_t scoreQ[$];
   int   checks = 0;
   int   errors = 0;
   int   modelCount = 0;
   int   expMissed = 0;
   int   seenMissed = 0;

   logic       mPrevGate;
   int         mGateLen;
   logic [3:0] mB1;
   logic [3:0] mB2;
   logic       mS1;
   logic       mS2;

   parking_occupancy_ctrl #(
      .CAPACITY        (CAP),
      .GATE_CYCLES     (GATE),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .entry_sensor  (entry_sensor),
      .exit_sensor   (exit_sensor),
      .add_sub_s     (add_sub_s),
      .add_a         (add_a),
      .add_b         (add_b),
      .add_sum       (add_sum),
      .count         (count),
      .full          (full),
      .empty         (empty),
      .gate_in_open  (gate_in_open),
      .gate_out_open (gate_out_open),
      .reject        (reject),
      .missed        (missed)
   );

   // Free-running system clock, 10 time units per period.
   always #5 clk = ~clk;

   // External 4-bit adder/subtractor: subtraction is A + ~B + 1, so Sum[4] is the no-borrow flag.
   assign add_sum = add_sub_s ? ({1'b0, add_a} + {1'b0, ~add_b} + 5'd1)
                              : ({1'b0, add_a} + {1'b0, add_b});

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Occupancy model: each accepted car changes the count by one, refusals leave it alone.
   task automatic expectEntry();
      exp_t e;
      if (modelCount == CAP) begin
         e.kind = K_REJ;
      end else begin
         modelCount++;
         e.kind = K_ADD;
      end
      e.cnt = modelCount;
      scoreQ.push_back(e);
   endtask

   task automatic expectExit();
      exp_t e;
      if (modelCount == 0) begin
         e.kind = K_REJ;
      end else begin
         modelCount--;
         e.kind = K_SUB;
      end
      e.cnt = modelCount;
      scoreQ.push_back(e);
   endtask

   task automatic expectNet();
      exp_t e;
      e.kind = K_NET;
      e.cnt  = modelCount;
      scoreQ.push_back(e);
   endtask

   task automatic pulse(input logic doIn, input logic doOut, input int width);
      @(posedge clk);
      #1;
      entry_sensor = doIn;
      exit_sensor  = doOut;
      repeat (width) @(posedge clk);
      #1;
      entry_sensor = 1'b0;
      exit_sensor  = 1'b0;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while ((scoreQ.size() != 0 || gate_in_open || gate_out_open) && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (n >= 100) begin
         checkOutput("idleTimeout", int'(scoreQ.size()) + int'(gate_in_open) + int'(gate_out_open), 0);
         scoreQ.delete();
      end
      repeat (6) @(posedge clk);
   endtask

   // Scenario kinds: 0 entry, 1 exit, 2 entry and exit together, 3 entry burst with one dropped edge.
   task automatic applyStimulus(input int kind);
      case (kind)
         0: begin
            expectEntry();
            pulse(1'b1, 1'b0, 3);
         end
         1: begin
            expectExit();
            pulse(1'b0, 1'b1, 3);
         end
         2: begin
            expectNet();
            pulse(1'b1, 1'b1, 3);
         end
         default: begin
            if (modelCount < CAP) begin
               // Second car arrives during the first gate and waits; the third arrives while it still waits.
               expectEntry();
               expectEntry();
               expMissed++;
               pulse(1'b1, 1'b0, 2);
               repeat (3) @(posedge clk);
               pulse(1'b1, 1'b0, 2);
               repeat (1) @(posedge clk);
               pulse(1'b1, 1'b0, 2);
            end else begin
               expectEntry();
               pulse(1'b1, 1'b0, 3);
            end
         end
      endcase
      waitIdle();
   endtask

   // Monitor: pops one predicted event per reject pulse or gate opening and checks it.
   initial begin : monitor
      exp_t  e;
      kind_t obsKind;
      logic  curGate;
      mPrevGate = 1'b0;
      mGateLen  = 0;
      mB1 = 4'd0;
      mB2 = 4'd0;
      mS1 = 1'b0;
      mS2 = 1'b0;
      forever begin
         @(negedge clk);
         curGate = gate_in_open | gate_out_open;
         if (reset) begin
            mPrevGate = 1'b0;
            mGateLen  = 0;
            mB1 = 4'd0;
            mB2 = 4'd0;
            mS1 = 1'b0;
            mS2 = 1'b0;
         end else begin
            if (missed) seenMissed++;
            if (reject) begin
               if (scoreQ.size() == 0) begin
                  checkOutput("unexpectedReject", int'(reject), 0);
               end else begin
                  e = scoreQ.pop_front();
                  checkOutput("eventKind", int'(K_REJ), int'(e.kind));
                  checkOutput("rejCount", int'(count), e.cnt);
                  checkOutput("rejAddB", int'(add_b), 0);
                  checkOutput("rejFull", int'(full), int'(e.cnt == CAP));
                  checkOutput("rejEmpty", int'(empty), int'(e.cnt == 0));
               end
            end
            if (curGate && !mPrevGate) begin
               if (scoreQ.size() == 0) begin
                  checkOutput("unexpectedGate", int'(curGate), 0);
               end else begin
                  e = scoreQ.pop_front();
                  if (gate_in_open && gate_out_open) obsKind = K_NET;
                  else if (gate_in_open)             obsKind = K_ADD;
                  else                               obsKind = K_SUB;
                  checkOutput("eventKind", int'(obsKind), int'(e.kind));
                  checkOutput("gateCount", int'(count), e.cnt);
                  checkOutput("gateAddA", int'(add_a), e.cnt);
                  checkOutput("issueAddB", int'(mB2), (e.kind == K_NET) ? 0 : 1);
                  checkOutput("issueAddS", int'(mS2), int'(e.kind == K_SUB));
                  checkOutput("gateFull", int'(full), int'(e.cnt == CAP));
                  checkOutput("gateEmpty", int'(empty), int'(e.cnt == 0));
               end
            end
            if (curGate) begin
               mGateLen++;
            end else if (mPrevGate) begin
               checkOutput("gateLength", mGateLen, GATE);
               mGateLen = 0;
            end
            mB2 = mB1;
            mB1 = add_b;
            mS2 = mS1;
            mS1 = add_sub_s;
            mPrevGate = curGate;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin : main
      int n;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstCount", int'(count), 0);
      checkOutput("rstEmpty", int'(empty), 1);
      checkOutput("rstFull", int'(full), 0);
      checkOutput("rstGateIn", int'(gate_in_open), 0);
      checkOutput("rstGateOut", int'(gate_out_open), 0);
      checkOutput("rstReject", int'(reject), 0);
      checkOutput("rstMissed", int'(missed), 0);
      checkOutput("rstAddB", int'(add_b), 0);
      checkOutput("rstAddS", int'(add_sub_s), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(posedge clk);

      $display("[TB] three clean entries");
      repeat (3) applyStimulus(0);

      $display("[TB] fill to capacity, then one refused entry");
      while (modelCount < CAP) applyStimulus(0);
      applyStimulus(0);
      checkOutput("fullFlag", int'(full), 1);
      checkOutput("fullCount", int'(count), CAP);
      checkOutput("fullGateIn", int'(gate_in_open), 0);

      $display("[TB] simultaneous entry and exit at count 5");
      while (modelCount > 5) applyStimulus(1);
      applyStimulus(2);
      checkOutput("netCount", int'(count), 5);

      $display("[TB] empty lot, refused exit, then entry");
      while (modelCount > 0) applyStimulus(1);
      applyStimulus(1);
      checkOutput("emptyFlag", int'(empty), 1);
      checkOutput("emptyCount", int'(count), 0);
      applyStimulus(0);
      checkOutput("afterEmptyEntry", int'(count), 1);

      $display("[TB] entry burst with dropped edge");
      applyStimulus(3);

      $display("[TB] random traffic");
      for (int i = 0; i < 40; i++) begin
         applyStimulus(int'($urandom_range(0, 3)));
      end

      $display("[TB] reset during open gate at count 7");
      while (modelCount < 6) applyStimulus(0);
      while (modelCount > 6) applyStimulus(1);
      expectEntry();
      pulse(1'b1, 1'b0, 3);
      n = 0;
      while (!gate_in_open && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("gateBeforeReset", int'(gate_in_open), 1);
      checkOutput("countBeforeReset", int'(count), 7);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("midRstGateIn", int'(gate_in_open), 0);
      checkOutput("midRstGateOut", int'(gate_out_open), 0);
      checkOutput("midRstCount", int'(count), 0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      modelCount = 0;
      scoreQ.delete();
      repeat (4) @(posedge clk);
      #1;
      checkOutput("postRstCount", int'(count), 0);
      checkOutput("postRstEmpty", int'(empty), 1);
      checkOutput("postRstGateIn", int'(gate_in_open), 0);
      applyStimulus(0);
      checkOutput("recoverCount", int'(count), 1);

      checkOutput("missedCount", seenMissed, expMissed);
      checkOutput("queueLeft", int'(scoreQ.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
